probe_trace_buffer: RTL and testbench
=====================================

# probe_trace_buffer

Consumer end of the core's fetch/decode probe interface. Each enabled cycle it captures the decode-stage probe fields and tags them with a sequence number. It cross-checks them against the fetch-stage probes registered one cycle earlier, re-slicing the fetched instruction. Results are buffered in a FIFO and drained over a valid/ready stream to the testbench logger or a debug port inside `design_wrapper`.

## Interface
Parameters:
- `DWIDTH`, 32: PC / instruction / immediate width.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `capture_en` in 1: capture this cycle's decode probes.
- `f_pc` in DWIDTH: fetch PC probe.
- `f_insn` in DWIDTH: fetch instruction probe.
- `d_pc` in DWIDTH: decode PC probe.
- `d_opcode` in 7: decode opcode probe.
- `d_rd` in 5: decode rd probe.
- `d_funct3` in 3: decode funct3 probe.
- `d_rs1` in 5: decode rs1 probe.
- `d_rs2` in 5: decode rs2 probe.
- `d_funct7` in 7: decode funct7 probe.
- `d_imm` in DWIDTH: decode immediate probe.
- `d_shamt` in 5: decode shamt probe.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: sink accepts head.
- `out_data` out `trace_rec_t`: FIFO head record.
- `overflow` out 1: sticky; a record was dropped.
- `drop_count` out 16: dropped records, saturating at 0xFFFF.
- `err` out 1: sticky; a consistency check failed.
- `err_count` out 16: failed checks, saturating at 0xFFFF.

## Operation
- Fetch shadow: every cycle, `f_pc_q <= f_pc`, `f_insn_q <= f_insn`, `f_vld_q <= 1`. `f_vld_q` is 0 only in the first cycle after reset release.
- Check, combinational, in capture cycle N, only when `f_vld_q`:
  - mismatch if `d_pc != f_pc_q`, or
  - `d_opcode != f_insn_q[6:0]`, `d_rd != [11:7]`, `d_funct3 != [14:12]`, `d_rs1 != [19:15]`, `d_rs2 != [24:20]`, `d_funct7 != [31:25]`.
- `d_imm` and `d_shamt` are recorded only; they are not checked.
- Record fields: `seq`[15:0], `chk` (1 = check performed), `mis` (1 = mismatch), `d_pc`, `d_opcode`, `d_rd`, `d_funct3`, `d_rs1`, `d_rs2`, `d_funct7`, `d_imm`, `d_shamt`.
- Sequence counter: `seq` increments on every `capture_en` cycle, including dropped ones, and wraps 0xFFFF→0. A dropped record therefore shows as a gap in `seq`.
- Error tracking: `mis` sets `err` and increments `err_count`, whether or not the record is stored.
- Push: on `capture_en` when `count < DEPTH`, or when `count == DEPTH` and a pop happens the same cycle.
- Drop: otherwise the new record is dropped; `overflow` sets and `drop_count` increments. Existing entries are never overwritten.
- Pop: when `out_valid && out_ready`.
- Push and pop in the same cycle: `count` is unchanged; both pointers advance and wrap modulo DEPTH.
- Reset: all outputs 0. `out_data` is 0, `seq`=0, `count`=0, pointers are 0, `f_vld_q`=0. Reset asserted mid-stream discards all buffered records.

## Timing
- A record captured in cycle N is visible on `out_valid`/`out_data` from cycle N+1 at the earliest (registered count; head read from the storage array).
- `out_data` is stable while `out_valid && !out_ready`.
- `out_valid` never depends combinationally on `out_ready`.
- `overflow`, `err` and the counters update at the edge ending the triggering cycle.
- Throughput: one push plus one pop per cycle.

## Structure
- `trace_pkg` contains:
  - the packed struct `trace_rec_t`, sized for DWIDTH=32;
  - the constants `SEQ_W`=16 and `CNT_W`=16;
  - the instruction field bit-range localparams used by the checker.
- One sub-module, `trace_fifo`: a parameterised sync FIFO over `trace_rec_t` with push, pop, full, empty and count.
- Capture, check and counters are implemented in the top.

## Test plan
- Reset, then cycle 1 with `capture_en`=1 and `d_pc`=0x0 → record has `seq`=0, `chk`=0, `mis`=0; `out_valid`=1 at cycle 2.
- `f_pc`=0x1000, `f_insn`=0x00A30293 at cycle N; matching decode fields at N+1 (`d_pc`=0x1000, opcode 0x13, rd 5, funct3 0, rs1 6) → `chk`=1, `mis`=0, `err`=0.
- Same stimulus but `d_rd`=4 → `mis`=1, `err`=1, `err_count`=1; the record is still stored.
- `out_ready`=0 with 20 captures at DEPTH=16 → 16 stored, `overflow`=1, `drop_count`=4. Draining yields `seq` 0..15 in order.
- Full FIFO with `out_ready`=1 and `capture_en`=1 in the same cycle → `count` stays 16, no drop, head `seq` advances by 1.
- Reset asserted with 5 records buffered → `out_valid`=0 immediately and all counters 0. The next capture has `seq`=0 and `chk`=0.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: trace record layout, counter widths and instruction field ranges
package trace_pkg;
    localparam int SEQ_W = 16;
    localparam int CNT_W = 16;
    localparam int OPC_LO = 0;
    localparam int OPC_HI = 6;
    localparam int RD_LO = 7;
    localparam int RD_HI = 11;
    localparam int F3_LO = 12;
    localparam int F3_HI = 14;
    localparam int RS1_LO = 15;
    localparam int RS1_HI = 19;
    localparam int RS2_LO = 20;
    localparam int RS2_HI = 24;
    localparam int F7_LO = 25;
    localparam int F7_HI = 31;
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic chk;
        logic mis;
        logic [31:0] d_pc;
        logic [6:0] d_opcode;
        logic [4:0] d_rd;
        logic [2:0] d_funct3;
        logic [4:0] d_rs1;
        logic [4:0] d_rs2;
        logic [6:0] d_funct7;
        logic [31:0] d_imm;
        logic [4:0] d_shamt;
    } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of trace records with simultaneous push/pop at full
module trace_fifo import trace_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  trace_rec_t din,
    output trace_rec_t dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    trace_rec_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // head forced to zero when empty so reset shows an all-zero record
    assign dout = empty ? '0 : mem[rptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/probe_trace_buffer.sv
// probe_trace_buffer: captures decode probes, checks them against last cycle's fetch, buffers records
module probe_trace_buffer import trace_pkg::*; #(
    parameter int DWIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic capture_en,
    input  logic [DWIDTH-1:0] f_pc,
    input  logic [DWIDTH-1:0] f_insn,
    input  logic [DWIDTH-1:0] d_pc,
    input  logic [6:0] d_opcode,
    input  logic [4:0] d_rd,
    input  logic [2:0] d_funct3,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic [6:0] d_funct7,
    input  logic [DWIDTH-1:0] d_imm,
    input  logic [4:0] d_shamt,
    output logic out_valid,
    input  logic out_ready,
    output trace_rec_t out_data,
    output logic overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic err,
    output logic [CNT_W-1:0] err_count
);
    logic [DWIDTH-1:0] f_pc_q, f_insn_q;
    logic f_vld_q;
    logic [SEQ_W-1:0] seq;
    logic mis, pop, drop, full, empty;
    logic [$clog2(DEPTH):0] count;
    trace_rec_t rec;
    assign pop = out_valid && out_ready;
    assign out_valid = !empty;
    assign drop = capture_en && full && !pop;
    assign mis = f_vld_q && (d_pc != f_pc_q || d_opcode != f_insn_q[OPC_HI:OPC_LO] ||
        d_rd != f_insn_q[RD_HI:RD_LO] || d_funct3 != f_insn_q[F3_HI:F3_LO] ||
        d_rs1 != f_insn_q[RS1_HI:RS1_LO] || d_rs2 != f_insn_q[RS2_HI:RS2_LO] ||
        d_funct7 != f_insn_q[F7_HI:F7_LO]);
    assign rec = '{seq: seq, chk: f_vld_q, mis: mis, d_pc: d_pc, d_opcode: d_opcode, d_rd: d_rd,
        d_funct3: d_funct3, d_rs1: d_rs1, d_rs2: d_rs2, d_funct7: d_funct7, d_imm: d_imm,
        d_shamt: d_shamt};
    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(capture_en), .pop(pop), .din(rec),
        .dout(out_data), .full(full), .empty(empty), .count(count)
    );
    always_comb assert (reset || full == (count == ($clog2(DEPTH)+1)'(DEPTH)));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q <= '0;
            f_insn_q <= '0;
            f_vld_q <= 1'b0;
            seq <= '0;
            err <= 1'b0;
            err_count <= '0;
            overflow <= 1'b0;
            drop_count <= '0;
        end else begin
            f_pc_q <= f_pc;
            f_insn_q <= f_insn;
            f_vld_q <= 1'b1;
            if (capture_en) seq <= seq + 1'b1;
            // errors count even when the record itself is dropped
            if (capture_en && mis) begin
                err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_probe_trace_buffer.sv
// tb_probe_trace_buffer: directed table vectors plus overflow, full-bypass and reset sequences
module tb_probe_trace_buffer;
    import trace_pkg::*;
    logic clk = 0, reset = 1, capture_en = 0, out_ready = 0;
    logic [31:0] f_pc = 32'h1000, f_insn = 32'h00A30293, d_pc = 0, d_imm = 0;
    logic [6:0] d_opcode = 0, d_funct7 = 0;
    logic [4:0] d_rd = 0, d_rs1 = 0, d_rs2 = 0, d_shamt = 0;
    logic [2:0] d_funct3 = 0;
    logic out_valid, overflow, err;
    logic [15:0] drop_count, err_count;
    trace_rec_t out_data;
    int tests = 0, fails = 0;

    probe_trace_buffer #(.DWIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .capture_en(capture_en), .f_pc(f_pc), .f_insn(f_insn),
        .d_pc(d_pc), .d_opcode(d_opcode), .d_rd(d_rd), .d_funct3(d_funct3), .d_rs1(d_rs1),
        .d_rs2(d_rs2), .d_funct7(d_funct7), .d_imm(d_imm), .d_shamt(d_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .drop_count(drop_count), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cap;
        logic [31:0] dpc;
        logic [31:0] dinsn;
        logic rdy;
        logic ev;
        logic [15:0] eseq;
        logic echk;
        logic emis;
        logic eerr;
        logic [15:0] ecnt;
    } vec_t;
    vec_t v [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cap, input logic [31:0] dp, input logic [31:0] di, input logic rdy);
        capture_en = cap;
        d_pc = dp;
        d_opcode = di[6:0];
        d_rd = di[11:7];
        d_funct3 = di[14:12];
        d_rs1 = di[19:15];
        d_rs2 = di[24:20];
        d_funct7 = di[31:25];
        d_imm = ~di;
        d_shamt = di[24:20];
        out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        drive(0, 0, 0, 0);
        tick();
        reset = 0;
    endtask

    initial begin
        v[0] = '{1, 32'h0, 32'h0, 0, 1, 16'd0, 0, 0, 0, 16'd0};
        v[1] = '{1, 32'h1000, 32'h00A30293, 1, 1, 16'd1, 1, 0, 0, 16'd0};
        v[2] = '{1, 32'h1000, 32'h00A30213, 1, 1, 16'd2, 1, 1, 1, 16'd1};
        v[3] = '{0, 32'h0, 32'h0, 1, 0, 16'd0, 0, 0, 1, 16'd1};
        v[4] = '{1, 32'h2000, 32'h00A30293, 0, 1, 16'd3, 1, 1, 1, 16'd2};
        v[5] = '{1, 32'h1000, 32'h00A30293, 0, 1, 16'd3, 1, 1, 1, 16'd2};

        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data[31:0], 0);
        check("reset_err", err, 0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            drive(v[i].cap, v[i].dpc, v[i].dinsn, v[i].rdy);
            tick();
            check($sformatf("v%0d_valid", i), out_valid, v[i].ev);
            if (v[i].ev) begin
                check($sformatf("v%0d_seq", i), out_data.seq, v[i].eseq);
                check($sformatf("v%0d_chk", i), out_data.chk, v[i].echk);
                check($sformatf("v%0d_mis", i), out_data.mis, v[i].emis);
            end
            check($sformatf("v%0d_err", i), err, v[i].eerr);
            check($sformatf("v%0d_err_count", i), err_count, v[i].ecnt);
        end

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0);
            tick();
            if (i == 15) check("fill16_overflow", overflow, 0);
        end
        check("fill_overflow", overflow, 1);
        check("fill_drop_count", drop_count, 4);
        check("fill_head_seq", out_data.seq, 0);

        drive(1, 0, 0, 1);
        tick();
        check("bypass_valid", out_valid, 1);
        check("bypass_head_seq", out_data.seq, 1);
        check("bypass_drop_count", drop_count, 4);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1);
            check($sformatf("drain%0d_valid", i), out_valid, 1);
            check($sformatf("drain%0d_seq", i), out_data.seq, i < 15 ? i + 1 : 20);
            tick();
        end
        check("drained_valid", out_valid, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hdead, 0, 0);
            tick();
        end
        check("pre_rst_err", err, 1);
        check("pre_rst_err_count", err_count, 4);
        check("pre_rst_valid", out_valid, 1);
        reset = 1;
        drive(0, 0, 0, 0);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        tick();
        reset = 0;
        drive(1, 0, 0, 0);
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_seq", out_data.seq, 0);
        check("post_rst_chk", out_data.chk, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
